// File: rtl/tx_dac_ramp_gate_module_if.sv
// I/Q sample stream between the DDS source, the ramp/gain gate and the DAC.
// Signal names keep the upstream "vaild" spelling so netlists line up with the source block.
interface tx_dac_ramp_gate_module_if;
    logic               vaild;
    logic signed [15:0] i;
    logic signed [15:0] q;

    modport master (output vaild, i, q);
    modport slave  (input  vaild, i, q);
endinterface

// File: rtl/tx_dac_ramp_gate_module.sv
// TX key-up/key-down amplitude ramp plus saturating digital gain in front of the DAC.
// Fixed 3-cycle latency: S1 ramp multiply, S2 ramp shift + gain multiply, S3 gain shift + saturate.
module tx_dac_ramp_gate_module #(
    parameter int RAMP_SHIFT = 6,
    parameter int GAIN_FRAC  = 7
) (
    input  logic                              clk_msk_in,
    input  logic                              logic_rst_in,
    input  logic                              tx_en_in,
    input  logic [7:0]                        mif_dac_gain,
    tx_dac_ramp_gate_module_if.slave          din,
    tx_dac_ramp_gate_module_if.master         dout,
    output logic                              dac_tx_on,
    output logic                              ramp_busy
);
    localparam int KW  = RAMP_SHIFT + 1;
    localparam int P1W = 16 + KW + 1;
    localparam int P2W = 16 + 9;
    localparam logic [KW-1:0] K_MAX = {1'b1, {RAMP_SHIFT{1'b0}}};
    localparam logic [KW-1:0] K_ONE = KW'(1);
    localparam logic signed [P2W-1:0] SAT_HI = P2W'(32767);
    localparam logic signed [P2W-1:0] SAT_LO = -P2W'(32768);

    typedef enum logic [1:0] {IDLE, RAMP_UP, ON, RAMP_DOWN} state_e;

    state_e                state_q;
    logic [KW-1:0]         k_q;
    logic                  ramp_busy_q;
    logic [2:0]            vld_q;
    logic [2:0]            on_q;
    logic signed [P1W-1:0] p1_i_q, p1_q_q;
    logic signed [P2W-1:0] p2_i_q, p2_q_q;
    logic signed [15:0]    r_i_d, r_q_d;
    logic signed [15:0]    dout_i_q, dout_q_q;
    logic                  dac_tx_on_q;

    function automatic logic signed [15:0] gain_sat(input logic signed [P2W-1:0] p);
        logic signed [P2W-1:0] s;
        s = p >>> GAIN_FRAC;
        if (s > SAT_HI)      return 16'sd32767;
        else if (s < SAT_LO) return -16'sd32768;
        else                 return 16'(s);
    endfunction

    // k moves by exactly one per accepted sample; direction reversal never skips a step.
    always_ff @(posedge clk_msk_in) begin
        if (logic_rst_in) begin
            state_q     <= IDLE;
            k_q         <= '0;
            ramp_busy_q <= 1'b0;
        end else if (din.vaild) begin
            case (state_q)
                IDLE: begin
                    k_q <= '0;
                    if (tx_en_in) begin
                        state_q     <= RAMP_UP;
                        k_q         <= K_ONE;
                        ramp_busy_q <= 1'b1;
                    end
                end
                RAMP_UP, RAMP_DOWN: begin
                    if (tx_en_in) begin
                        k_q <= k_q + K_ONE;
                        if (k_q + K_ONE == K_MAX) begin
                            state_q     <= ON;
                            ramp_busy_q <= 1'b0;
                        end else begin
                            state_q     <= RAMP_UP;
                            ramp_busy_q <= 1'b1;
                        end
                    end else begin
                        k_q <= k_q - K_ONE;
                        if (k_q == K_ONE) begin
                            state_q     <= IDLE;
                            ramp_busy_q <= 1'b0;
                        end else begin
                            state_q     <= RAMP_DOWN;
                            ramp_busy_q <= 1'b1;
                        end
                    end
                end
                ON: begin
                    k_q <= K_MAX;
                    if (!tx_en_in) begin
                        state_q     <= RAMP_DOWN;
                        k_q         <= K_MAX - K_ONE;
                        ramp_busy_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    k_q         <= '0;
                    ramp_busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Floor shift by RAMP_SHIFT; the product is bounded so the result always fits 16 bits.
    assign r_i_d = $signed(16'(p1_i_q >>> RAMP_SHIFT));
    assign r_q_d = $signed(16'(p1_q_q >>> RAMP_SHIFT));

    always_ff @(posedge clk_msk_in) begin
        if (logic_rst_in) begin
            vld_q       <= '0;
            on_q        <= '0;
            p1_i_q      <= '0;
            p1_q_q      <= '0;
            p2_i_q      <= '0;
            p2_q_q      <= '0;
            dout_i_q    <= '0;
            dout_q_q    <= '0;
            dac_tx_on_q <= 1'b0;
        end else begin
            vld_q  <= {vld_q[1:0], din.vaild};
            on_q   <= {on_q[1:0], state_q != IDLE};
            p1_i_q <= din.i * $signed({1'b0, k_q});
            p1_q_q <= din.q * $signed({1'b0, k_q});
            p2_i_q <= r_i_d * $signed({1'b0, mif_dac_gain});
            p2_q_q <= r_q_d * $signed({1'b0, mif_dac_gain});
            if (vld_q[1]) begin
                dout_i_q    <= gain_sat(p2_i_q);
                dout_q_q    <= gain_sat(p2_q_q);
                dac_tx_on_q <= on_q[1];
            end
        end
    end

    assign dout.vaild = vld_q[2];
    assign dout.i     = dout_i_q;
    assign dout.q     = dout_q_q;
    assign dac_tx_on  = dac_tx_on_q;
    assign ramp_busy  = ramp_busy_q;
endmodule

// File: tb/tb_tx_dac_ramp_gate_module.sv
// Randomised and directed stimulus with a saturating-counter amplitude model and a
// cycle-tagged scoreboard drained by an independent output monitor.
module tb_tx_dac_ramp_gate_module;
    logic       clk = 1'b0;
    logic       rst;
    logic       tx_en;
    logic [7:0] gain;
    logic       dac_tx_on;
    logic       ramp_busy;

    tx_dac_ramp_gate_module_if din_if ();
    tx_dac_ramp_gate_module_if dout_if ();

    tx_dac_ramp_gate_module dut (
        .clk_msk_in  (clk),
        .logic_rst_in(rst),
        .tx_en_in    (tx_en),
        .mif_dac_gain(gain),
        .din         (din_if),
        .dout        (dout_if),
        .dac_tx_on   (dac_tx_on),
        .ramp_busy   (ramp_busy)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int di;
        int dq;
        int k;
        int cyc;
        int on;
    } item_t;

    item_t sb[$];
    int    gain_hist[int];
    int    mk = 0;
    int    checks = 0;
    int    errors = 0;
    int    last_i = 0;
    int    last_q = 0;
    bit    armed = 0;
    bit    chk_rst = 0;
    int    cur_g = 128;
    bit    cur_tx = 0;

    function automatic int fdiv(int a, int b);
        return (a >= 0) ? a / b : -((-a + b - 1) / b);
    endfunction

    // Amplitude scaled by k/64, then by gain/128, each step rounded toward -inf, then clamped.
    function automatic int shape(int d, int k, int g);
        int s;
        s = fdiv(fdiv(d * k, 64) * g, 128);
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        item_t it;
        int    g, ei, eq;
        if (armed) begin
            if (dout_if.vaild === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_dout_vaild", 1, 0);
                end else begin
                    it = sb.pop_front();
                    g  = gain_hist.exists(it.cyc + 1) ? gain_hist[it.cyc + 1] : 0;
                    ei = shape(it.di, it.k, g);
                    eq = shape(it.dq, it.k, g);
                    check("latency", cyc - it.cyc, 3);
                    check("dout_i", int'(dout_if.i), ei);
                    check("dout_q", int'(dout_if.q), eq);
                    check("dac_tx_on", int'(dac_tx_on), it.on);
                    last_i = ei;
                    last_q = eq;
                end
            end else begin
                check("hold_i", int'(dout_if.i), last_i);
                check("hold_q", int'(dout_if.q), last_q);
            end
        end
    end

    task automatic step(bit r, bit tx, bit v, int i, int q, int g);
        @(negedge clk);
        #2;
        if (chk_rst) begin
            check("reset_outputs",
                  int'({dout_if.vaild, dac_tx_on, ramp_busy, dout_if.i != 0, dout_if.q != 0}), 0);
            chk_rst = 0;
        end else if (armed) begin
            check("ramp_busy", int'(ramp_busy), int'(mk > 0 && mk < 64));
        end
        rst          = r;
        tx_en        = tx;
        din_if.vaild = v;
        din_if.i     = 16'(i);
        din_if.q     = 16'(q);
        gain         = 8'(g);
        gain_hist[cyc] = g;
        if (r) begin
            sb.delete();
            mk      = 0;
            last_i  = 0;
            last_q  = 0;
            chk_rst = 1;
            armed   = 1;
        end else if (v) begin
            sb.push_back('{i, q, mk, cyc, int'(mk != 0)});
            mk = tx ? ((mk < 64) ? mk + 1 : 64) : ((mk > 0) ? mk - 1 : 0);
        end
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 128);
        repeat (3) step(0, 0, 1, 16384, -16384, 128);
        // ramp up, hold ON, ramp down
        repeat (70) step(0, 1, 1, 16384, -16384, 128);
        repeat (70) step(0, 0, 1, 16384, -16384, 128);
        // reversal at k=20
        for (int n = 0; n < 200 && mk != 20; n++) step(0, 1, 1, 16384, -16384, 128);
        repeat (5) step(0, 0, 1, 16384, -16384, 128);
        for (int n = 0; n < 200 && mk != 64; n++) step(0, 1, 1, 16384, -16384, 128);
        check("reached_on", mk, 64);
        // saturation and floor rounding at full amplitude
        repeat (2) step(0, 1, 1, 32767, -32768, 255);
        repeat (2) step(0, 1, 1, -32768, 32767, 255);
        repeat (2) step(0, 1, 1, 1001, -1001, 64);
        repeat (2) step(0, 1, 1, -1001, 1001, 64);
        // back to idle, then gapped ramp-up
        repeat (70) step(0, 0, 1, 12345, -777, 128);
        for (int n = 0; n < 90; n++) step(0, 1, (n % 3) == 0, 20000 - n, n - 9000, 128);
        // reset mid-ramp at k=30 and restart
        repeat (70) step(0, 0, 1, 5000, -5000, 128);
        for (int n = 0; n < 200 && mk != 30; n++) step(0, 1, 1, 8000, -8000, 200);
        check("at_k30", mk, 30);
        step(1, 1, 1, 8000, -8000, 200);
        repeat (70) step(0, 1, 1, 8000, -8000, 200);
        // randomised traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 39) == 0) cur_tx = ~cur_tx;
            if ($urandom_range(0, 3) == 0) cur_g = int'($urandom_range(0, 255));
            step($urandom_range(0, 499) == 0, cur_tx, $urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                 cur_g);
        end
        repeat (6) step(0, 0, 0, 0, 0, 128);
        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
